// File: rtl/pinpon_autoplayer.sv
// -----------------------------------------------------------------------------
// pinpon_autoplayer
//
// Automatic opponent for the pinpon game. Watches the game's 8-bit LED bus and
// produces the raw key press for one side, in place of that side's push button.
// The ball is returned when it steps from the pre-hit LED onto the hit LED. The
// robot also serves after a long stretch with every LED dark.
//
// Optional feature: define AUTOPLAYER_MISS_EN to add a free-running 8-bit LFSR
// and the miss_thresh port. The robot then deliberately misses some arrivals.
// The miss happens whenever lfsr < miss_thresh at the moment it would start
// reacting.
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  asynchronous, active-high reset
//   enable       in   1  1 = robot plays; 0 = key_out low, FSM held in IDLE
//   serve_en     in   1  1 = robot may serve after IDLE_CYC dark cycles
//   led_in       in   8  game LED bus (same clock domain)
//   miss_thresh  in   8  miss probability threshold (AUTOPLAYER_MISS_EN only)
//   key_out      out  1  raw key to the game, active high, registered
//   busy         out  1  high whenever the FSM is not in IDLE
//   hit_cnt      out  8  returns + serves issued, wraps 255 -> 0
// -----------------------------------------------------------------------------
module pinpon_autoplayer #(
  parameter int SIDE        = 0,
  parameter int REACT_CYC   = 1000,
  parameter int PRESS_CYC   = 64,
  parameter int HOLDOFF_CYC = 4096,
  parameter int IDLE_CYC    = 2**26,
  parameter int CNT_W       = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       serve_en,
  input  logic [7:0] led_in,
`ifdef AUTOPLAYER_MISS_EN
  input  logic [7:0] miss_thresh,
`endif
  output logic       key_out,
  output logic       busy,
  output logic [7:0] hit_cnt
);

  // Right player hits on led[0] (ball comes from led[1]); left on led[7]/led[6].
  localparam logic [7:0] HIT_MASK = (SIDE == 0) ? 8'h01 : 8'h80;
  localparam logic [7:0] PRE_MASK = (SIDE == 0) ? 8'h02 : 8'h40;

  // Terminal counts; every state compares the shared counter for equality.
  localparam logic [CNT_W-1:0] REACT_LAST = CNT_W'(REACT_CYC - 1);
  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REACT = 2'd1,
    ST_PRESS = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       led_q;
  logic [7:0]       led_p;
  logic [7:0]       hit_cnt_q;
  logic             key_q;

  logic             arrive;
  logic             dark;
  logic             miss;

  // Ball stepped from the pre-hit LED onto the hit LED between the last two
  // samples. Flicker patterns such as 0x0F/0xF0 can never match both masks.
  assign arrive = (led_q == HIT_MASK) && (led_p == PRE_MASK);
  assign dark   = serve_en && (led_q == 8'h00);

`ifdef AUTOPLAYER_MISS_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting toward the MSB every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign miss = (lfsr_q < miss_thresh);
`else
  assign miss = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      led_q     <= 8'h00;
      led_p     <= 8'h00;
      hit_cnt_q <= 8'h00;
      key_q     <= 1'b0;
    end else begin
      led_q <= led_in;
      led_p <= led_q;

      if (!enable) begin
        // Disabled: park in IDLE with the key released; the score is kept.
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        key_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (arrive) begin
              // Arrival outranks serving (they cannot coincide anyway).
              cnt_q <= '0;
              if (!miss) begin
                state_q <= ST_REACT;
              end
            end else if (dark) begin
              if (cnt_q == IDLE_LAST) begin
                state_q <= ST_PRESS;
                cnt_q   <= '0;
                key_q   <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              // Any lit LED (or serving disabled) restarts the dark count.
              cnt_q <= '0;
            end
          end

          ST_REACT: begin
            if (cnt_q == REACT_LAST) begin
              state_q <= ST_PRESS;
              cnt_q   <= '0;
              key_q   <= 1'b1;
            end else if (led_q != HIT_MASK) begin
              // Ball left the hit LED before we swung: give up quietly.
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          ST_PRESS: begin
            if (cnt_q == PRESS_LAST) begin
              state_q   <= ST_HOLD;
              cnt_q     <= '0;
              key_q     <= 1'b0;
              hit_cnt_q <= hit_cnt_q + 8'd1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          ST_HOLD: begin
            // Key held low so the debouncer sees a clean release; arrivals
            // during this window are ignored.
            if (cnt_q == HOLD_LAST) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign key_out = key_q;
  assign busy    = (state_q != ST_IDLE);
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_pinpon_autoplayer.sv
// -----------------------------------------------------------------------------
// tb_pinpon_autoplayer
//
// Directed bench for pinpon_autoplayer with small timing parameters
// (REACT=4, PRESS=8, HOLDOFF=16, IDLE=64, right side). Inputs are driven and
// outputs sampled on the falling clock edge; each scenario task checks inline.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pinpon_autoplayer;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       serve_en;
  logic [7:0] led_in;
  logic       key_out;
  logic       busy;
  logic [7:0] hit_cnt;
`ifdef AUTOPLAYER_MISS_EN
  logic [7:0] miss_thresh;
  logic [7:0] m_lfsr;
`endif

  int checks;
  int failures;
  int exp_hits;

  pinpon_autoplayer #(
    .SIDE       (0),
    .REACT_CYC  (4),
    .PRESS_CYC  (8),
    .HOLDOFF_CYC(16),
    .IDLE_CYC   (64),
    .CNT_W      (27)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .serve_en   (serve_en),
    .led_in     (led_in),
`ifdef AUTOPLAYER_MISS_EN
    .miss_thresh(miss_thresh),
`endif
    .key_out    (key_out),
    .busy       (busy),
    .hit_cnt    (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef AUTOPLAYER_MISS_EN
  // Reference LFSR (x^8+x^6+x^5+x^4+1, seed 0x01, one step per clock).
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 8'h01;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
`endif

  // Ball moves 0x02 -> 0x01; returns on the falling edge where 0x01 is driven.
  task automatic present_arrival();
    @(negedge clk); led_in = 8'h02;
    @(negedge clk); led_in = 8'h01;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; serve_en = 1'b0; led_in = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (key_out !== 1'b0 || busy !== 1'b0 || hit_cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: key=%b busy=%b hit=%0d, want 0/0/0", key_out, busy, hit_cnt);
    end
    rst = 1'b0;
    exp_hits = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  // 0x01 sampled on the edge after it is driven; key rises REACT+1 = 5 clocks
  // later (offset 6 from the drive edge), stays 8 clocks, then >=16 low.
  task automatic test_return();
    int first;
    int last;
    int highs;
    first = -1; last = -1; highs = 0;
    present_arrival();
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (key_out === 1'b1) begin
        if (first < 0) first = i;
        last = i;
        highs++;
      end
    end
    exp_hits++;
    checks++;
    if (first !== 6) begin
      failures++;
      $display("FAIL return_latency: first high at %0d, want 6", first);
    end
    checks++;
    if (highs !== 8 || last !== 13) begin
      failures++;
      $display("FAIL return_width: highs=%0d last=%0d, want 8 and 13", highs, last);
    end
    checks++;
    if (hit_cnt !== 8'(exp_hits)) begin
      failures++;
      $display("FAIL return_hitcnt: hit_cnt=%0d want %0d", hit_cnt, exp_hits);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL return_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_midpress();
    int waited;
    waited = 0;
    present_arrival();
    while (key_out !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (key_out !== 1'b1) begin
      failures++;
      $display("FAIL midpress_reach: key=%b never rose within 20 clk", key_out);
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (key_out !== 1'b0 || busy !== 1'b0 || hit_cnt !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: key=%b busy=%b hit=%0d, want 0/0/0", key_out, busy, hit_cnt);
    end
    led_in = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_hits = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || key_out !== 1'b0 || hit_cnt !== 8'h00) begin
      failures++;
      $display("FAIL post_reset_idle: key=%b busy=%b hit=%0d, want 0/0/0", key_out, busy, hit_cnt);
    end
  endtask

  task automatic test_early_exit();
    logic saw_key;
    logic saw_busy;
    saw_key = 1'b0; saw_busy = 1'b0;
    present_arrival();
    @(negedge clk);                 // 0x01 held for a second clock
    @(negedge clk); led_in = 8'h00;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (key_out === 1'b1) saw_key = 1'b1;
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b1) begin
      failures++;
      $display("FAIL early_react: busy never high, want REACT entered");
    end
    checks++;
    if (saw_key !== 1'b0) begin
      failures++;
      $display("FAIL early_nopress: key pulsed=%b want 0", saw_key);
    end
    checks++;
    if (busy !== 1'b0 || hit_cnt !== 8'(exp_hits)) begin
      failures++;
      $display("FAIL early_idle: busy=%b hit=%0d, want 0 and %0d", busy, hit_cnt, exp_hits);
    end
  endtask

  // serve_en raised at offset 0 with the bus dark. lit_at: offset at which
  // 0x10 is driven for one clock (-1 = never).
  task automatic test_serve(input int lit_at, input int exp_first);
    int first;
    int highs;
    first = -1; highs = 0;
    for (int i = 0; i <= exp_first + 40; i++) begin
      @(negedge clk);
      if (i > 0 && key_out === 1'b1) begin
        if (first < 0) first = i;
        highs++;
      end
      serve_en = (i < exp_first + 4);
      led_in   = (i == lit_at) ? 8'h10 : 8'h00;
    end
    exp_hits++;
    checks++;
    if (first !== exp_first) begin
      failures++;
      $display("FAIL serve_latency(lit=%0d): first high at %0d, want %0d", lit_at, first, exp_first);
    end
    checks++;
    if (highs !== 8) begin
      failures++;
      $display("FAIL serve_width(lit=%0d): highs=%0d want 8", lit_at, highs);
    end
    checks++;
    if (hit_cnt !== 8'(exp_hits)) begin
      failures++;
      $display("FAIL serve_hitcnt: hit_cnt=%0d want %0d", hit_cnt, exp_hits);
    end
  endtask

  task automatic test_flicker();
    logic saw_key;
    logic saw_busy;
    saw_key = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      led_in = (i % 2 == 0) ? 8'h0F : 8'h00;
      if (key_out === 1'b1) saw_key = 1'b1;
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    led_in = 8'h00;
    checks++;
    if (saw_key !== 1'b0 || saw_busy !== 1'b0) begin
      failures++;
      $display("FAIL flicker: key=%b busy=%b seen, want 0/0", saw_key, saw_busy);
    end
  endtask

  task automatic test_enable_drop();
    logic saw_key;
    saw_key = 1'b0;
    present_arrival();
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL enable_react: busy=%b want 1", busy);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || key_out !== 1'b0) begin
      failures++;
      $display("FAIL enable_idle: busy=%b key=%b want 0/0", busy, key_out);
    end
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (key_out === 1'b1) saw_key = 1'b1;
    end
    checks++;
    if (saw_key !== 1'b0 || hit_cnt !== 8'(exp_hits)) begin
      failures++;
      $display("FAIL enable_nopress: key=%b hit=%0d, want 0 and %0d", saw_key, hit_cnt, exp_hits);
    end
  endtask

  // A second arrival shown during the holdoff window must not be returned.
  task automatic test_back_to_back();
    int waited;
    int rises;
    logic prev;
    waited = 0; rises = 0;
    present_arrival();
    while (key_out !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    while (key_out !== 1'b0 && waited < 40) begin @(negedge clk); waited++; end
    checks++;
    if (waited >= 40 || key_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: key=%b after %0d clk, want pulse done", key_out, waited);
    end
    exp_hits++;
    led_in = 8'h00;
    present_arrival();
    prev = key_out;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_out === 1'b1 && prev !== 1'b1) rises++;
      prev = key_out;
    end
    checks++;
    if (rises !== 0 || hit_cnt !== 8'(exp_hits)) begin
      failures++;
      $display("FAIL b2b_holdoff: extra presses=%0d hit=%0d, want 0 and %0d", rises, hit_cnt, exp_hits);
    end
  endtask

`ifdef AUTOPLAYER_MISS_EN
  task automatic test_miss(input logic [7:0] thresh);
    int rises;
    int exp_presses;
    logic prev;
    rises = 0; exp_presses = 0;
    miss_thresh = thresh;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); led_in = 8'h00;
      present_arrival();
      @(negedge clk);               // arrive visible; LFSR decides at next edge
      if (!(m_lfsr < thresh)) exp_presses++;
      prev = key_out;
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        if (key_out === 1'b1 && prev !== 1'b1) rises++;
        prev = key_out;
      end
    end
    if (thresh == 8'h00) exp_presses = 20;
    exp_hits += exp_presses;
    checks++;
    if (rises !== exp_presses) begin
      failures++;
      $display("FAIL miss_presses(th=%02h): presses=%0d want %0d", thresh, rises, exp_presses);
    end
    checks++;
    if (hit_cnt !== 8'(exp_hits)) begin
      failures++;
      $display("FAIL miss_hitcnt(th=%02h): hit=%0d want %0d", thresh, hit_cnt, exp_hits);
    end
    miss_thresh = 8'h00;
  endtask
`endif

  initial begin
    checks = 0; failures = 0; exp_hits = 0;
`ifdef AUTOPLAYER_MISS_EN
    miss_thresh = 8'h00;
`endif
    test_reset();
    $display("test_reset done: checks=%0d failures=%0d", checks, failures);
    test_return();
    $display("test_return done: hit_cnt=%0d", hit_cnt);
    test_reset_midpress();
    $display("test_reset_midpress done: hit_cnt=%0d", hit_cnt);
    test_early_exit();
    $display("test_early_exit done: hit_cnt=%0d", hit_cnt);
    test_serve(-1, 64);
    $display("test_serve plain done: hit_cnt=%0d", hit_cnt);
    test_serve(39, 105);
    $display("test_serve restart done: hit_cnt=%0d", hit_cnt);
    test_flicker();
    $display("test_flicker done");
    test_enable_drop();
    $display("test_enable_drop done: hit_cnt=%0d", hit_cnt);
    test_back_to_back();
    $display("test_back_to_back done: hit_cnt=%0d", hit_cnt);
    test_return();
    $display("test_return (repeat) done: hit_cnt=%0d", hit_cnt);
`ifdef AUTOPLAYER_MISS_EN
    test_miss(8'hFF);
    $display("test_miss FF done: hit_cnt=%0d", hit_cnt);
    test_miss(8'h00);
    $display("test_miss 00 done: hit_cnt=%0d", hit_cnt);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
